// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag helpers for the ALU board front end.
package alu_pkg;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_NOR = 6'b100111;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_EXEC = 2'd3
    } state_t;

    // Signed overflow from operand/result sign bits; subtraction flips the operand-sign test.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic r_msb, input logic is_sub);
        if (is_sub) begin
            return (a_msb != b_msb) && (r_msb != a_msb);
        end
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus counting debouncer; emits the debounced level and a press pulse.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]       r_sync;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // Level flips on the DEB_CYCLES-th consecutive sample that disagrees with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_btn};
            r_press <= 1'b0;
            if (r_sync[1] != r_level) begin
                if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    r_level <= r_sync[1];
                    r_press <= r_sync[1];
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/alu_io_sequencer.sv
// Board front end: debounced LOAD/CLEAR buttons sequence A, B and opcode captures into a registered ALU.
module alu_io_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned NB_DATA    = 8,
    parameter int unsigned NB_CODE    = 6,
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NB_DATA-1:0] i_switch,
    input  logic               i_btn_load,
    input  logic               i_btn_clear,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_zero,
    output logic               o_carry,
    output logic               o_overflow,
    output logic               o_err,
    output logic               o_valid,
    output logic [1:0]         o_state
);

    localparam int unsigned MSB = NB_DATA - 1;

    logic w_load_press, w_load_lvl;
    logic w_clr_press, w_clr_lvl;
    logic [1:0] w_unused_levels;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
        .clk(clk), .rst(rst), .i_btn(i_btn_load), .o_level(w_load_lvl), .o_press(w_load_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clk(clk), .rst(rst), .i_btn(i_btn_clear), .o_level(w_clr_lvl), .o_press(w_clr_press)
    );

    assign w_unused_levels = {w_load_lvl, w_clr_lvl};

    state_t             r_state;
    logic [NB_DATA-1:0] r_a, r_b, r_result;
    logic [NB_CODE-1:0] r_op;
    logic               r_zero, r_carry, r_ovf, r_err, r_valid;

    logic [NB_DATA:0]   w_sum, w_diff;
    logic [NB_DATA-1:0] w_res;
    logic               w_carry, w_ovf, w_err, w_shift_big;

    assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff      = {1'b0, r_a} - {1'b0, r_b};
    assign w_shift_big = (r_b >= NB_DATA'(NB_DATA));

    // Combinational datapath on the held operands; only sampled in S_EXEC.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (r_op)
            NB_CODE'(OP_ADD): begin
                w_res   = w_sum[MSB:0];
                w_carry = w_sum[NB_DATA];
                w_ovf   = signed_ovf(r_a[MSB], r_b[MSB], w_sum[MSB], 1'b0);
            end
            NB_CODE'(OP_SUB): begin
                w_res   = w_diff[MSB:0];
                w_carry = w_diff[NB_DATA];
                w_ovf   = signed_ovf(r_a[MSB], r_b[MSB], w_diff[MSB], 1'b1);
            end
            NB_CODE'(OP_AND): w_res = r_a & r_b;
            NB_CODE'(OP_OR):  w_res = r_a | r_b;
            NB_CODE'(OP_XOR): w_res = r_a ^ r_b;
            NB_CODE'(OP_NOR): w_res = ~(r_a | r_b);
            NB_CODE'(OP_SRA): w_res = w_shift_big ? {NB_DATA{r_a[MSB]}}
                                                  : NB_DATA'($signed(r_a) >>> r_b);
            NB_CODE'(OP_SRL): w_res = w_shift_big ? '0 : (r_a >> r_b);
            default:          w_err = 1'b1;
        endcase
    end

    // Capture sequencer; a clear event overrides any load in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_A;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_carry  <= 1'b0;
            r_ovf    <= 1'b0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_clr_press) begin
                r_state  <= S_A;
                r_result <= '0;
                r_zero   <= 1'b0;
                r_carry  <= 1'b0;
                r_ovf    <= 1'b0;
                r_err    <= 1'b0;
            end else begin
                case (r_state)
                    S_A: if (w_load_press) begin
                        r_a     <= i_switch;
                        r_state <= S_B;
                    end
                    S_B: if (w_load_press) begin
                        r_b     <= i_switch;
                        r_state <= S_OP;
                    end
                    S_OP: if (w_load_press) begin
                        r_op    <= i_switch[NB_CODE-1:0];
                        r_state <= S_EXEC;
                    end
                    S_EXEC: begin
                        r_result <= w_res;
                        r_zero   <= (w_res == '0);
                        r_carry  <= w_carry;
                        r_ovf    <= w_ovf;
                        r_err    <= w_err;
                        r_valid  <= 1'b1;
                        r_state  <= S_OP;
                    end
                    default: r_state <= S_A;
                endcase
            end
        end
    end

    assign o_result   = r_result;
    assign o_zero     = r_zero;
    assign o_carry    = r_carry;
    assign o_overflow = r_ovf;
    assign o_err      = r_err;
    assign o_valid    = r_valid;
    assign o_state    = r_state;

endmodule

// File: tb/tb_alu_io_sequencer.sv
// Directed bench for alu_io_sequencer: button sequencing, ALU results/flags, debounce, clear and reset.
module tb_alu_io_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] i_switch;
    logic       i_btn_load;
    logic       i_btn_clear;
    logic [7:0] o_result;
    logic       o_zero, o_carry, o_overflow, o_err, o_valid;
    logic [1:0] o_state;

    int checks = 0;
    int fails  = 0;
    int vcount = 0;
    int vbase  = 0;

    alu_io_sequencer #(.NB_DATA(8), .NB_CODE(6), .DEB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .i_switch(i_switch), .i_btn_load(i_btn_load),
        .i_btn_clear(i_btn_clear), .o_result(o_result), .o_zero(o_zero), .o_carry(o_carry),
        .o_overflow(o_overflow), .o_err(o_err), .o_valid(o_valid), .o_state(o_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (o_valid === 1'b1) vcount++;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Clean press: held long enough to debounce and complete an execute, then released.
    task automatic press_load(input logic [7:0] sw);
        i_switch   = sw;
        i_btn_load = 1'b1;
        tick(10);
        i_btn_load = 1'b0;
        tick(10);
    endtask

    task automatic press_clear();
        i_btn_clear = 1'b1;
        tick(10);
        i_btn_clear = 1'b0;
        tick(10);
    endtask

    task automatic chk_op(input string tag, input logic [5:0] op, input logic [7:0] res,
                          input logic z, input logic c, input logic v);
        vbase = vcount;
        press_load({2'b00, op});
        chk({tag, "_res"}, o_result, res);
        chk({tag, "_zero"}, o_zero, z);
        chk({tag, "_carry"}, o_carry, c);
        chk({tag, "_ovf"}, o_overflow, v);
        chk({tag, "_err"}, o_err, 0);
        chk({tag, "_vpulses"}, vcount - vbase, 1);
        chk({tag, "_state"}, o_state, 2);
    endtask

    initial begin
        rst = 1'b1;
        i_switch = 8'h00;
        i_btn_load = 1'b0;
        i_btn_clear = 1'b0;
        tick(3);
        chk("rst_result", o_result, 0);
        chk("rst_flags", {o_zero, o_carry, o_overflow, o_err, o_valid}, 0);
        chk("rst_state", o_state, 0);
        rst = 1'b0;
        tick(2);

        // 1: ADD with latency check, then re-execute SUB/AND/NOR on held operands
        press_load(8'h10);
        chk("load_a_state", o_state, 1);
        press_load(8'h07);
        chk("load_b_state", o_state, 2);
        vbase = vcount;
        i_switch   = 8'h20;
        i_btn_load = 1'b1;
        tick(7);
        chk("add_exec_state", o_state, 3);
        chk("add_valid_early", o_valid, 0);
        tick(1);
        chk("add_valid_2clk", o_valid, 1);
        chk("add_res", o_result, 8'h17);
        chk("add_cv", {o_carry, o_overflow}, 0);
        tick(1);
        chk("add_valid_drop", o_valid, 0);
        tick(1);
        i_btn_load = 1'b0;
        tick(10);
        chk("add_vpulses", vcount - vbase, 1);
        chk_op("sub1", 6'b100010, 8'h09, 1'b0, 1'b0, 1'b0);
        chk_op("and1", 6'b100100, 8'h00, 1'b1, 1'b0, 1'b0);
        chk_op("nor1", 6'b100111, 8'hE8, 1'b0, 1'b0, 1'b0);

        // 2: signed overflow on ADD, borrow on SUB
        press_clear();
        chk("clr_state", o_state, 0);
        chk("clr_result", o_result, 0);
        press_load(8'h7F);
        press_load(8'h01);
        chk_op("add_ovf", 6'b100000, 8'h80, 1'b0, 1'b0, 1'b1);
        press_clear();
        press_load(8'h00);
        press_load(8'h01);
        chk_op("sub_borrow", 6'b100010, 8'hFF, 1'b0, 1'b1, 1'b0);

        // 3: shifts, including shift amount beyond the width
        press_clear();
        press_load(8'h80);
        press_load(8'h02);
        chk_op("sra2", 6'b000011, 8'hE0, 1'b0, 1'b0, 1'b0);
        chk_op("srl2", 6'b000010, 8'h20, 1'b0, 1'b0, 1'b0);
        press_clear();
        press_load(8'h80);
        press_load(8'h09);
        chk_op("sra9", 6'b000011, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk_op("srl9", 6'b000010, 8'h00, 1'b1, 1'b0, 1'b0);

        // 4: short glitch is rejected, long hold gives one event
        press_clear();
        i_switch   = 8'h33;
        i_btn_load = 1'b1;
        tick(3);
        i_btn_load = 1'b0;
        tick(10);
        chk("glitch_state", o_state, 0);
        i_btn_load = 1'b1;
        tick(50);
        i_btn_load = 1'b0;
        tick(10);
        chk("hold_state", o_state, 1);

        // 5: unsupported opcode, then simultaneous clear and load
        press_load(8'h01);
        vbase = vcount;
        press_load(8'h3E);
        chk("err_flag", o_err, 1);
        chk("err_result", o_result, 0);
        chk("err_zero", o_zero, 1);
        chk("err_cv", {o_carry, o_overflow}, 0);
        chk("err_vpulses", vcount - vbase, 1);
        vbase = vcount;
        i_switch    = 8'h20;
        i_btn_load  = 1'b1;
        i_btn_clear = 1'b1;
        tick(10);
        i_btn_load  = 1'b0;
        i_btn_clear = 1'b0;
        tick(10);
        chk("both_state", o_state, 0);
        chk("both_result", o_result, 0);
        chk("both_flags", {o_zero, o_carry, o_overflow, o_err}, 0);
        chk("both_vpulses", vcount - vbase, 0);

        // 6: reset landing on the execute cycle suppresses the result
        press_load(8'h03);
        press_load(8'h04);
        vbase = vcount;
        i_switch   = 8'h20;
        i_btn_load = 1'b1;
        tick(7);
        chk("rst_exec_state", o_state, 3);
        rst        = 1'b1;
        i_btn_load = 1'b0;
        tick(1);
        chk("rstx_state", o_state, 0);
        chk("rstx_result", o_result, 0);
        chk("rstx_flags", {o_zero, o_carry, o_overflow, o_err, o_valid}, 0);
        rst = 1'b0;
        tick(10);
        chk("rstx_vpulses", vcount - vbase, 0);
        chk("rstx_state_hold", o_state, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
